// File: rtl/sync_tx.sv
// Serial frame transmitter: sends PREAMBLE, then DATA_W payload bits MSB first,
// then an even-parity bit, on a registered one-bit stream.
module sync_tx #(
  parameter logic [3:0] PREAMBLE = 4'b1101,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  output logic              ready,
  output logic              x,
  output logic              frame,
  output logic              done,
  output logic [1:0]        state
);

  // Handshake: a request is taken on a rising edge where send=1 and ready=1;
  // send is ignored at any other time, and data_in is only sampled then.

  // Shift register holds the bits still to go after the one currently on x.
  localparam int SW = DATA_W + 3;
  localparam int CW = (DATA_W > 4) ? $clog2(DATA_W) : 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic            par_q, par_d;
  logic            x_q, x_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    x_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d = SYNC;
          cnt_d   = CW'(3);
          sh_d    = {PREAMBLE[2:0], data_in};
          par_d   = ^data_in;
          x_d     = PREAMBLE[3];
        end
      end
      SYNC: begin
        // Counter holds the index of the preamble bit now on x.
        x_d  = sh_q[SW-1];
        sh_d = {sh_q[SW-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CW'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        x_d  = sh_q[SW-1];
        sh_d = {sh_q[SW-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = PAR;
          x_d     = par_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PAR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sh_d    = '0;
        par_d   = 1'b0;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign frame = (state_q != IDLE);
  assign x     = x_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_sync_tx.sv
// Bench for sync_tx: directed and random frames checked bit-by-bit against
// frames built from the preamble/payload/parity rules.
module tb_sync_tx;

  localparam int         W    = 8;
  localparam logic [3:0] PRE  = 4'b1101;
  localparam int         FLEN = 4 + W + 1;

  logic         clk;
  logic         reset;
  logic         send;
  logic [W-1:0] data_in;
  logic         ready;
  logic         x;
  logic         frame;
  logic         done;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];

  // 1101 detector watching the serial line, plus position within the frame
  int         det_total = 0;
  int         det_pos   = -1;
  int         frame_pos = 0;
  logic [3:0] hist      = 4'b0;

  sync_tx #(.PREAMBLE(PRE), .DATA_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .send    (send),
    .ready   (ready),
    .x       (x),
    .frame   (frame),
    .done    (done),
    .state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      hist      = 4'b0;
      frame_pos = 0;
    end else begin
      frame_pos = frame ? frame_pos + 1 : 0;
      if ({hist[2:0], x} == 4'b1101) begin
        det_total++;
        det_pos = frame_pos;
      end
      hist = {hist[2:0], x};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_x", x, 0);
      check("idle_ready", ready, 1);
      check("idle_frame", frame, 0);
      check("idle_done", done, 0);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after the
  // frame, where done must be high.
  task automatic run_frame(input logic [W-1:0] d, input bit keep_send, input int glitch_at);
    exp_q.delete();
    for (int i = 3; i >= 0; i--) exp_q.push_back(PRE[i]);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(^d);
    check("accept_ready", ready, 1);
    send    = 1'b1;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    if (!keep_send) send = 1'b0;
    if (!keep_send) data_in = W'($urandom);
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("bit%0d", i), x, exp_q.pop_front());
      check($sformatf("frame%0d", i), frame, 1);
      check($sformatf("busy%0d", i), ready, 0);
      check($sformatf("nodone%0d", i), done, 0);
      if (glitch_at >= 0 && i == glitch_at) begin
        send    = 1'b1;
        data_in = '1;
      end else if (glitch_at >= 0 && i == glitch_at + 1) begin
        send = 1'b0;
      end
      @(negedge clk);
    end
    check("end_x", x, 0);
    check("end_frame", frame, 0);
    check("end_ready", ready, 1);
    check("end_done", done, 1);
  endtask

  initial begin
    logic [W-1:0] d;
    int           det0;
    bit           keep;

    reset   = 1'b0;
    send    = 1'b0;
    data_in = '0;
    #1;
    check("rst_x", x, 0);
    check("rst_frame", frame, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2);

    run_frame(8'hA5, 0, -1);
    idle(1);
    run_frame(8'h01, 0, -1);
    idle(2);

    // send held high across two frames: exactly one idle cycle between them
    run_frame(8'h0F, 1, -1);
    run_frame(8'hF0, 0, -1);
    idle(1);

    // extra pulse and data change mid-payload must not disturb the frame
    run_frame(8'h3C, 0, 6);
    idle(3);

    // asynchronous reset during data bit 3
    d       = 8'h5A;
    send    = 1'b1;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_bit3", x, d[3]);
    #2 reset = 1'b0;
    #1;
    check("abort_x", x, 0);
    check("abort_frame", frame, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inrst_done", done, 0);
      check("inrst_ready", ready, 1);
      check("inrst_frame", frame, 0);
    end
    send  = 1'b0;
    reset = 1'b1;
    idle(1);
    run_frame(8'hC3, 0, -1);
    idle(1);

    // one preamble detection per all-zero frame
    idle(4);
    det0 = det_total;
    run_frame(8'h00, 0, -1);
    idle(4);
    check("det_count", det_total - det0, 1);
    check("det_pos", det_pos, 4);

    // random payloads, random gaps, occasional back-to-back
    for (int n = 0; n < 10; n++) begin
      d    = W'($urandom);
      keep = (n != 9) && ($urandom_range(0, 1) == 1);
      run_frame(d, keep, -1);
      if (!keep) idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
